// File: rtl/sfx_scheduler.sv
// Arbitrates the note_gen tone path between BGM passthrough and four prioritised
// one-shot sound effects, each played as two tones of TONE_TICKS cycles.
module sfx_scheduler #(
    parameter int          TONE_TICKS  = 12_500_000,
    parameter logic [25:0] SILENT_FREQ = 26'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mute,
    input  logic [25:0] bgm_freqL,
    input  logic [25:0] bgm_freqR,
    input  logic [3:0]  sfx_req,
    output logic [25:0] freqL,
    output logic [25:0] freqR,
    output logic        sfx_busy,
    output logic [1:0]  sfx_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TONE_A = 2'd1,
        TONE_B = 2'd2
    } state_e;

    localparam int             CW        = $clog2(TONE_TICKS);
    localparam logic [CW-1:0]  TICK_LAST = CW'(TONE_TICKS - 1);

    state_e        state_q, state_d;
    logic [3:0]    pending_q, pending_d;
    logic [CW-1:0] tick_q, tick_d;
    logic [1:0]    id_q, id_d;
    logic [25:0]   freq_l_q, freq_l_d;
    logic [25:0]   freq_r_q, freq_r_d;
    logic          busy_q, busy_d;

    logic [3:0]    req_new;
    logic [3:0]    play_mask;
    logic [3:0]    req_all;
    logic [1:0]    winner;

    function automatic logic [25:0] tone_a(input logic [1:0] id);
        case (id)
            2'd0:    tone_a = 26'd784;
            2'd1:    tone_a = 26'd523;
            2'd2:    tone_a = 26'd659;
            default: tone_a = 26'd262;
        endcase
    endfunction

    function automatic logic [25:0] tone_b(input logic [1:0] id);
        case (id)
            2'd0:    tone_b = 26'd1047;
            2'd1:    tone_b = 26'd392;
            2'd2:    tone_b = 26'd880;
            default: tone_b = 26'd196;
        endcase
    endfunction

    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        if (v[0])      lowest_idx = 2'd0;
        else if (v[1]) lowest_idx = 2'd1;
        else if (v[2]) lowest_idx = 2'd2;
        else           lowest_idx = 2'd3;
    endfunction

    // A pulse for the effect already playing is dropped rather than latched.
    always_comb begin
        req_new   = mute ? 4'b0000 : sfx_req;
        play_mask = (state_q == IDLE) ? 4'b0000 : (4'b0001 << id_q);
        req_all   = pending_q | (req_new & ~play_mask);
        winner    = lowest_idx(req_all);
    end

    // NOTE: every next-state signal gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pending_d = req_all;
        tick_d    = tick_q;
        id_d      = id_q;

        if (mute) begin
            state_d   = IDLE;
            pending_d = 4'b0000;
            tick_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_all) begin
                        state_d   = TONE_A;
                        id_d      = winner;
                        pending_d = req_all & ~(4'b0001 << winner);
                        tick_d    = '0;
                    end
                end
                TONE_A, TONE_B: begin
                    if (|req_all && (winner < id_q)) begin
                        state_d   = TONE_A;
                        id_d      = winner;
                        pending_d = req_all & ~(4'b0001 << winner);
                        tick_d    = '0;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (state_q == TONE_A) begin
                            state_d = TONE_B;
                        end else if (|req_all) begin
                            state_d   = TONE_A;
                            id_d      = winner;
                            pending_d = req_all & ~(4'b0001 << winner);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + CW'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    pending_d = 4'b0000;
                    tick_d    = '0;
                end
            endcase
        end
    end

    // Outputs follow the next state so a request shows up one edge after it is sampled.
    always_comb begin
        freq_l_d = SILENT_FREQ;
        freq_r_d = SILENT_FREQ;
        busy_d   = 1'b0;
        case (state_d)
            TONE_A: begin
                freq_l_d = tone_a(id_d);
                freq_r_d = tone_a(id_d);
                busy_d   = 1'b1;
            end
            TONE_B: begin
                freq_l_d = tone_b(id_d);
                freq_r_d = tone_b(id_d);
                busy_d   = 1'b1;
            end
            default: begin
                if (!mute) begin
                    freq_l_d = bgm_freqL;
                    freq_r_d = bgm_freqR;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 4'b0000;
            tick_q    <= '0;
            id_q      <= 2'd0;
            freq_l_q  <= SILENT_FREQ;
            freq_r_q  <= SILENT_FREQ;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            id_q      <= id_d;
            freq_l_q  <= freq_l_d;
            freq_r_q  <= freq_r_d;
            busy_q    <= busy_d;
        end
    end

    assign freqL    = freq_l_q;
    assign freqR    = freq_r_q;
    assign sfx_busy = busy_q;
    assign sfx_id   = id_q;

endmodule
